// File: rtl/port_uart_pkg.sv
// port_uart_pkg: shared state encodings and port bit positions for port_uart.
package port_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // status (port09) bit positions
  localparam int ST_TX_ACK   = 0;
  localparam int ST_RX_TOG   = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FERR     = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_PERR     = 5;

  // ctrl (port01) bit positions
  localparam int CT_TX_REQ   = 0;
  localparam int CT_ERR_CLR  = 1;
  localparam int CT_RX_ACK   = 2;

  // Even parity bit for a data byte (1 when the byte has an odd number of ones)
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/port_uart_rx.sv
// port_uart_rx: rxd synchronizer plus receive FSM with sticky error flags.
// Build option: PORT_UART_PARITY_EN adds an even parity bit check before the stop bit.
module port_uart_rx
  import port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       err_clr,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_tog,
  output logic       overrun,
  output logic       framing_err,
  output logic       parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_tog_q, rx_tog_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s, cnt_last, good;
  logic          set_ovr, set_ferr;
`ifdef PORT_UART_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
  logic          set_perr;
`endif

  assign rxd_s    = sync_q[1];
  assign cnt_last = (cnt_q == CNT_LAST);

  // Next-state logic: start detection, mid-bit sampling, frame completion and flags
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], rxd};
    prev_d    = rxd_s;
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_tog_d  = rx_tog_q;
    set_ovr   = 1'b0;
    set_ferr  = 1'b0;
    good      = 1'b0;
`ifdef PORT_UART_PARITY_EN
    par_bad_d = par_bad_q;
    set_perr  = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rxd_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // A start bit that is high again at mid-bit was a glitch
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_last) begin
          shift_d = {rxd_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef PORT_UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef PORT_UART_PARITY_EN
      RX_PARITY: begin
        if (cnt_last) begin
          par_bad_d = (rxd_s != even_parity(shift_q));
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_last) begin
          state_d  = RX_IDLE;
          set_ferr = !rxd_s;
`ifdef PORT_UART_PARITY_EN
          set_perr = par_bad_q;
          good     = rxd_s && !par_bad_q;
`else
          good     = rxd_s;
`endif
          if (good) begin
            set_ovr   = (rx_ack != rx_tog_q);
            rx_data_d = shift_q;
            rx_tog_d  = !rx_tog_q;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Sticky flags: a set on the same edge as a clear wins
    ovr_d  = set_ovr  | (ovr_q  & !err_clr);
    ferr_d = set_ferr | (ferr_q & !err_clr);
`ifdef PORT_UART_PARITY_EN
    perr_d = set_perr | (perr_q & !err_clr);
`endif
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rx_tog_q  <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PORT_UART_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rx_tog_q  <= rx_tog_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
`ifdef PORT_UART_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_tog      = rx_tog_q;
  assign overrun     = ovr_q;
  assign framing_err = ferr_q;
`ifdef PORT_UART_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: rtl/port_uart.sv
// port_uart: device side of the YASAC port interface; toggle-handshake UART with
// the TX FSM here and the receiver in port_uart_rx.
// Build option: PORT_UART_PARITY_EN adds an even parity bit to every frame.
module port_uart
  import port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic [7:0] ctrl,
  output logic [7:0] status,
  output logic [7:0] rx_data,
  output logic       txd,
  input  logic       rxd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_req_q, tx_req_d;
  logic          tx_ack_q, tx_ack_d;
  logic          txd_q, txd_d;
  logic          tx_cnt_last, tx_busy;
  logic          rx_tog, rx_ovr, rx_ferr, rx_perr;
  logic          unused_ctrl;

  assign unused_ctrl = ^ctrl[7:3];
  assign tx_cnt_last = (tx_cnt_q == CNT_LAST);
  assign tx_busy     = (tx_state_q != TX_IDLE);

  // TX next-state: accept a request toggle in IDLE, then shift out one bit per CLKS_PER_BIT
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_req_d   = tx_req_q;
    tx_ack_d   = tx_ack_q;
    txd_d      = txd_q;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_last ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (ctrl[CT_TX_REQ] != tx_ack_q) begin
          tx_byte_d  = tx_data;
          tx_req_d   = ctrl[CT_TX_REQ];
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_last) begin
          tx_idx_d   = 3'd0;
          txd_d      = tx_byte_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_last) begin
          if (tx_idx_q == 3'd7) begin
`ifdef PORT_UART_PARITY_EN
            txd_d      = even_parity(tx_byte_q);
            tx_state_d = TX_PARITY;
`else
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            txd_d    = tx_byte_q[tx_idx_q + 3'd1];
          end
        end
      end
`ifdef PORT_UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_last) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_last) begin
          tx_ack_d   = tx_req_q;
          txd_d      = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        txd_d      = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX registers with synchronous active-low reset; txd idles high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_byte_q  <= 8'h00;
      tx_req_q   <= 1'b0;
      tx_ack_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_req_q   <= tx_req_d;
      tx_ack_q   <= tx_ack_d;
      txd_q      <= txd_d;
    end
  end

  port_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .err_clr    (ctrl[CT_ERR_CLR]),
    .rx_ack     (ctrl[CT_RX_ACK]),
    .rx_data    (rx_data),
    .rx_tog     (rx_tog),
    .overrun    (rx_ovr),
    .framing_err(rx_ferr),
    .parity_err (rx_perr)
  );

  // Status port assembly from registered flags
  always_comb begin
    status             = 8'h00;
    status[ST_TX_ACK]  = tx_ack_q;
    status[ST_RX_TOG]  = rx_tog;
    status[ST_OVERRUN] = rx_ovr;
    status[ST_FERR]    = rx_ferr;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_PERR]    = rx_perr;
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_port_uart.sv
// tb_port_uart: randomized self-checking bench for port_uart with a frame-level reference model.
`timescale 1ns/1ps
module tb_port_uart;
  import port_uart_pkg::*;

  localparam int N = 4;
`ifdef PORT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] ctrl = 8'h00;
  logic       rxd = 1'b1;
  logic [7:0] status;
  logic [7:0] rx_data;
  logic       txd;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model of the CPU-visible receive state
  logic [7:0] m_rx_data = 8'h00;
  logic       m_tog = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;

  always #5 clk = ~clk;

  port_uart #(.CLKS_PER_BIT(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_data(tx_data),
    .ctrl   (ctrl),
    .status (status),
    .rx_data(rx_data),
    .txd    (txd),
    .rxd    (rxd)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
  endtask

  // Serial line levels of one frame, in transmission order (index 0 = start bit)
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef PORT_UART_PARITY_EN
    f[9] = (($countones(b) % 2) == 1);
`endif
    return f;
  endfunction

  // Follow a frame that was latched on the preceding posedge; optionally poke ctrl/tx_data mid-frame
  task automatic watch_tx(input logic [7:0] b, input int n_retog, input logic [7:0] new_data);
    logic [10:0] f;
    logic        lat;
    f   = frame_bits(b);
    lat = ctrl[CT_TX_REQ];
    for (int c = 0; c < FB * N; c++) begin
      @(negedge clk);
      check_val("txd_bit", txd, f[c / N]);
      if (c % N == 0) check_val("tx_busy", status[ST_TX_BUSY], 1'b1);
      if (c == FB * N - 1) check_val("tx_ack_pre", status[ST_TX_ACK], !lat);
      if (c == 5 && n_retog > 0) begin
        tx_data = new_data;
        ctrl[CT_TX_REQ] = !ctrl[CT_TX_REQ];
      end
      if (c == 9 && n_retog > 1) ctrl[CT_TX_REQ] = !ctrl[CT_TX_REQ];
    end
    @(negedge clk);
    check_val("tx_ack", status[ST_TX_ACK], lat);
    check_val("tx_idle_busy", status[ST_TX_BUSY], 1'b0);
    check_val("tx_idle_txd", txd, 1'b1);
  endtask

  // Request one frame from a negedge while TX is idle and check it
  task automatic start_tx(input logic [7:0] b);
    tx_data = b;
    ctrl[CT_TX_REQ] = !ctrl[CT_TX_REQ];
    watch_tx(b, 0, 8'h00);
  endtask

  task automatic check_rx(input string tag);
    check_val({tag, "_data"}, rx_data, m_rx_data);
    check_val({tag, "_tog"}, status[ST_RX_TOG], m_tog);
    check_val({tag, "_ovr"}, status[ST_OVERRUN], m_ovr);
    check_val({tag, "_ferr"}, status[ST_FERR], m_ferr);
    check_val({tag, "_perr"}, status[ST_PERR], m_perr);
  endtask

  // Drive one frame onto rxd and update the model by the frame rules
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic par_flip);
    logic [10:0] f;
    logic        good;
    f = frame_bits(b);
    f[FB-1] = stop;
`ifdef PORT_UART_PARITY_EN
    f[9] = f[9] ^ par_flip;
    good = stop && !par_flip;
    if (par_flip) m_perr = 1'b1;
`else
    good = stop;
`endif
    for (int i = 0; i < FB; i++) begin
      rxd = f[i];
      repeat (N) @(negedge clk);
    end
    rxd = 1'b1;
    if (!stop) m_ferr = 1'b1;
    if (good) begin
      if (ctrl[CT_RX_ACK] != m_tog) m_ovr = 1'b1;
      m_rx_data = b;
      m_tog = !m_tog;
    end
    repeat (3 * N) @(negedge clk);
    check_rx("rx");
  endtask

  task automatic clear_err();
    ctrl[CT_ERR_CLR] = 1'b1;
    @(negedge clk);
    ctrl[CT_ERR_CLR] = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    @(negedge clk);
    check_rx("errclr");
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic       rp;

    // Power-on reset
    repeat (3) @(negedge clk);
    check_val("rst_txd", txd, 1'b1);
    check_val("rst_status", status, 8'h00);
    check_val("rst_rxdata", rx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a TX frame
    tx_data = 8'h81;
    ctrl[CT_TX_REQ] = 1'b1;
    repeat (10) @(negedge clk);
    check_val("pre_rst_txd", txd, 1'b0);
    rst_n = 1'b0;
    ctrl = 8'h00;
    repeat (2) @(negedge clk);
    check_val("midrst_txd", txd, 1'b1);
    check_val("midrst_status", status, 8'h00);
    check_val("midrst_rxdata", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("postrst_status", status, 8'h00);
    check_val("postrst_txd", txd, 1'b1);

    // Basic TX frame
    start_tx(8'hA5);
`ifdef PORT_UART_PARITY_EN
    start_tx(8'h07);
`endif

    // Back-to-back: second request and new data arrive while the first frame is busy
    tx_data = 8'h5A;
    ctrl[CT_TX_REQ] = !ctrl[CT_TX_REQ];
    watch_tx(8'h5A, 1, 8'hC3);
    watch_tx(8'hC3, 0, 8'h00);

    // Double toggle during busy gives no further frame
    tx_data = 8'h3E;
    ctrl[CT_TX_REQ] = !ctrl[CT_TX_REQ];
    watch_tx(8'h3E, 2, 8'hFF);
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      check_val("dbl_txd", txd, 1'b1);
      check_val("dbl_busy", status[ST_TX_BUSY], 1'b0);
    end

    // RX good byte, then overrun, then error clear
    send_rx(8'h3C, 1'b1, 1'b0);
    send_rx(8'hC5, 1'b1, 1'b0);
    clear_err();
    ctrl[CT_RX_ACK] = m_tog;

    // Glitch on rxd is ignored
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (3 * N) @(negedge clk);
    check_rx("glitch");

    // Framing error
    send_rx(8'h96, 1'b0, 1'b0);
    clear_err();

`ifdef PORT_UART_PARITY_EN
    // Parity mismatch discards the byte
    send_rx(8'h07, 1'b1, 1'b1);
    clear_err();
`endif

    // Randomized receive traffic with random acks and clears
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
`ifdef PORT_UART_PARITY_EN
      rp = ($urandom_range(0, 4) == 0);
`else
      rp = 1'b0;
`endif
      send_rx(rb, rs, rp);
      if ($urandom_range(0, 1) == 1) ctrl[CT_RX_ACK] = m_tog;
      if ($urandom_range(0, 2) == 0) clear_err();
    end

    // Randomized transmit bytes
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      start_tx(rb);
    end

    // TX and RX concurrently
    ctrl[CT_RX_ACK] = m_tog;
    rb = 8'($urandom);
    fork
      start_tx(8'h69);
      send_rx(rb, 1'b1, 1'b0);
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
